// File: rtl/adder32_pkg.sv
// adder32_pkg: widths and the per-stage register bundle shared by adder32_pipe and its slices
package adder32_pkg;
    localparam int SLICE_W = 4;
    localparam int DATA_W = 32;
    localparam int NSTAGE = DATA_W / SLICE_W;
    typedef struct packed {
        logic valid;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] a_rem;
        logic [DATA_W-1:0] b_rem;
        logic carry;
    } stage_t;
endpackage

// File: rtl/adder32_if.sv
// adder32_if: operand/result valid-ready bus for adder32_pipe; the sub port exists only when ADDER32_SUB_EN is defined
interface adder32_if;
    import adder32_pkg::*;
    logic in_valid, in_ready, out_valid, out_ready, ci, cf;
    logic [DATA_W-1:0] a, b, s;
`ifdef ADDER32_SUB_EN
    logic sub;
    modport master(output in_valid, a, b, ci, sub, out_ready, input in_ready, out_valid, s, cf);
    modport slave(input in_valid, a, b, ci, sub, out_ready, output in_ready, out_valid, s, cf);
`else
    modport master(output in_valid, a, b, ci, out_ready, input in_ready, out_valid, s, cf);
    modport slave(input in_valid, a, b, ci, out_ready, output in_ready, out_valid, s, cf);
`endif
endinterface

// File: rtl/add4_slice_reg.sv
// add4_slice_reg: one 4-bit ripple slice at bit offset K*SLICE_W plus its enabled, sync-reset pipeline register
module add4_slice_reg
    import adder32_pkg::*;
#(
    parameter int K = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);
    logic [SLICE_W:0] c;
    logic [SLICE_W-1:0] r;
    stage_t nxt;
    assign c[0] = d.carry;
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign r[i] = d.a_rem[i] ^ d.b_rem[i] ^ c[i];
        assign c[i+1] = (d.a_rem[i] & d.b_rem[i]) | (c[i] & (d.a_rem[i] ^ d.b_rem[i]));
    end
    always_comb begin
        nxt = d;
        nxt.sum = d.sum | (DATA_W'(r) << (K * SLICE_W));
        nxt.a_rem = d.a_rem >> SLICE_W;
        nxt.b_rem = d.b_rem >> SLICE_W;
        nxt.carry = c[SLICE_W];
    end
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (en) q <= nxt;
    end
endmodule

// File: rtl/adder32_pipe.sv
// adder32_pipe: 32-bit adder pipelined as NSTAGE registered 4-bit ripple slices with a global stall; ADDER32_SUB_EN adds a - b
module adder32_pipe
    import adder32_pkg::*;
(
    input logic clk,
    input logic rst,
    adder32_if.slave bus
);
    logic adv;
    logic unused;
    stage_t stg [NSTAGE+1];
    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
`ifdef ADDER32_SUB_EN
    assign stg[0] = '{valid: bus.in_valid, sum: '0, a_rem: bus.a,
                      b_rem: bus.sub ? ~bus.b : bus.b, carry: bus.sub | bus.ci};
`else
    assign stg[0] = '{valid: bus.in_valid, sum: '0, a_rem: bus.a, b_rem: bus.b, carry: bus.ci};
`endif
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        add4_slice_reg #(.K(k)) u_slice (
            .clk(clk),
            .rst(rst),
            .en (adv),
            .d  (stg[k]),
            .q  (stg[k+1])
        );
    end
    assign bus.out_valid = stg[NSTAGE].valid;
    assign bus.s = stg[NSTAGE].sum;
    assign bus.cf = stg[NSTAGE].carry;
    assign unused = ^{stg[NSTAGE].a_rem, stg[NSTAGE].b_rem};
endmodule
